// File: rtl/piston_mode_controller_pkg.sv
// rtl/piston_mode_controller_pkg.sv - shared modes, states, border constants and target arithmetic
package piston_mode_controller_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_TEMP   = 2'b01;
    localparam logic [1:0] MODE_MOL    = 2'b10;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SWITCH = 2'd1,
        ST_TRACK  = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int BORDER_MIN    = 1;
    localparam int BORDER_MAX    = 200;
    localparam int MOL_BASE      = 201;
    localparam int TEMP_BASE     = 161;
    localparam int STEP_PER_UNIT = 40;

    function automatic logic [1:0] decodeMode(input logic [1:0] sel);
        return (sel == 2'b11) ? MODE_MANUAL : sel;
    endfunction

    // Out-of-range indices are clamped first, then the signed result is saturated to the border range.
    function automatic logic [7:0] borderTarget(input logic useMol, input logic [2:0] tempIdx,
                                                input logic [2:0] moles);
        logic [2:0]        units;
        logic signed [8:0] base;
        logic signed [8:0] raw;
        if (useMol) begin
            units = (moles < 3'd1) ? 3'd1 : ((moles > 3'd5) ? 3'd5 : moles);
            base  = 9'(MOL_BASE);
        end else begin
            units = (tempIdx > 3'd4) ? 3'd4 : tempIdx;
            base  = 9'(TEMP_BASE);
        end
        raw = base - 9'(STEP_PER_UNIT) * $signed({6'd0, units});
        if (raw < 9'(BORDER_MIN)) return 8'(BORDER_MIN);
        if (raw > 9'(BORDER_MAX)) return 8'(BORDER_MAX);
        return raw[7:0];
    endfunction

endpackage

// File: rtl/piston_mode_controller_step_tick_gen.sv
// rtl/piston_mode_controller_step_tick_gen.sv - free-running divider producing one tick every DIV cycles
module step_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic clearn,
    output logic tick
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            count <= '0;
        end else if (count == CW'(DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == CW'(DIV - 1));

endmodule

// File: rtl/piston_mode_controller.sv
// rtl/piston_mode_controller.sv - selects piston motion source, computes target border and paces steps
module piston_mode_controller
    import piston_mode_controller_pkg::*;
#(
    parameter int STEP_DIV      = 4,
    parameter int TIMEOUT_TICKS = 255
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [1:0] mode_sel,
    input  logic       compress_btn,
    input  logic       expand_btn,
    input  logic [2:0] temp,
    input  logic [2:0] num_moles,
    input  logic [7:0] piston_q,
    output logic       step_en,
    output logic       compress,
    output logic       expand,
    output logic [1:0] mode_cur,
    output logic [7:0] target,
    output logic       settled,
    output logic       busy,
    output logic       fault
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    state_t        state;
    logic          tick;
    logic [1:0]    modeReq;
    logic          modeChange;
    logic          atTarget;
    logic [TW-1:0] toCount;

    step_tick_gen #(.DIV(STEP_DIV)) tickGen (
        .clk    (clk),
        .clearn (clearn),
        .tick   (tick)
    );

    assign modeReq    = decodeMode(mode_sel);
    assign modeChange = (modeReq != mode_cur);
    assign atTarget   = (piston_q == target);

    // Target follows the requested mode so it is already valid when SWITCH hands over to TRACK.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            target <= 8'(BORDER_MIN);
        end else if (modeReq != MODE_MANUAL) begin
            target <= borderTarget(modeReq == MODE_MOL, temp, num_moles);
        end
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state    <= ST_MANUAL;
            mode_cur <= MODE_MANUAL;
            toCount  <= '0;
            fault    <= 1'b0;
        end else if (state == ST_SWITCH) begin
            if (tick) begin
                mode_cur <= modeReq;
                fault    <= 1'b0;
                toCount  <= '0;
                state    <= (modeReq == MODE_MANUAL) ? ST_MANUAL : ST_TRACK;
            end
        end else if (modeChange) begin
            state <= ST_SWITCH;
        end else begin
            case (state)
                ST_TRACK: begin
                    if (atTarget) begin
                        state <= ST_HOLD;
                    end else if (tick) begin
                        if (toCount == TW'(TIMEOUT_TICKS - 1)) begin
                            fault <= 1'b1;
                            state <= ST_HOLD;
                        end else begin
                            toCount <= toCount + TW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (!atTarget && !fault) begin
                        state   <= ST_TRACK;
                        toCount <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Direction is decoded from the live state so motion stops the same cycle the piston arrives.
    always_comb begin
        compress = 1'b0;
        expand   = 1'b0;
        if (clearn) begin
            case (state)
                ST_MANUAL: begin
                    compress = compress_btn & ~expand_btn;
                    expand   = expand_btn & ~compress_btn;
                end
                ST_TRACK: begin
                    compress = (piston_q < target);
                    expand   = (piston_q > target);
                end
                default: ;
            endcase
        end
    end

    assign step_en = tick & (compress | expand);
    assign settled = clearn & ((state == ST_TRACK) | (state == ST_HOLD)) & atTarget;
    assign busy    = (state == ST_SWITCH) | (state == ST_TRACK);

endmodule

// File: doc/piston_mode_controller.md
Name: piston_mode_controller

Overview:
- Sequences the piston border counter.
- Selects which source drives piston motion: manual buttons, temperature-to-volume or moles-to-volume.
- Computes the target border, paces piston steps with a rate tick, and drives step enable and compress/expand toward the target.
- Sits between the switch/key front end and the border counter. The counter is run in its manual range (1..200) with its own mode enables held low.

Parameters:
- STEP_DIV, 4, clk cycles per piston step; legal range 2..255.
- TIMEOUT_TICKS, 255, step ticks allowed in TRACK before fault.

Ports:
- clk  in  1  system clock
- clearn  in  1  asynchronous active-low reset
- mode_sel  in  2  00 manual, 01 temp, 10 moles, 11 manual
- compress_btn  in  1  manual compress request (already debounced)
- expand_btn  in  1  manual expand request (already debounced)
- temp  in  3  temperature index, 0..4
- num_moles  in  3  mole count, 1..5
- piston_q  in  8  current border position fed back from the counter
- step_en  out  1  one-cycle step strobe to the counter enable
- compress  out  1  move direction: increase border
- expand  out  1  move direction: decrease border
- mode_cur  out  2  mode currently in control (00/01/10)
- target  out  8  registered target border (tracking modes)
- settled  out  1  piston_q == target in a tracking mode
- busy  out  1  SWITCH or TRACK state
- fault  out  1  sticky timeout flag

Behaviour:
- Reset: clearn low forces asynchronously:
  - state=MANUAL, mode_cur=00, target=1, tick counter=0.
  - step_en, compress, expand, settled, busy, fault all 0.
  - Reset asserted mid-move aborts the move immediately.
- Tick counter: counts 0..STEP_DIV-1 and wraps. tick=1 only when count==STEP_DIV-1. The counter free-runs in all states.
- Target arithmetic, 9-bit signed, registered every cycle:
  - mol_t = 201-40*clamp(num_moles,1,5)
  - temp_t = 161-40*clamp(temp,0,4)
  - Result saturates to 1..200.
  - Examples: moles 0→161, moles 7→1, temp 5→1.
- States: MANUAL, SWITCH, TRACK, HOLD. State is decoded as 2 bits.
- MANUAL:
  - compress=compress_btn & ~expand_btn; expand=expand_btn & ~compress_btn. Both pressed → neither.
  - step_en=tick & (compress|expand).
  - settled=0.
- Mode change detect: mode_sel decoded (11→00) differs from mode_cur in any state → go to SWITCH next cycle.
- SWITCH:
  - step_en, compress and expand are forced 0; busy=1.
  - On the next tick: load mode_cur from the decoded mode_sel and clear fault.
  - Go to MANUAL if the new mode is 00, else go to TRACK.
  - If mode_sel changes again during SWITCH, the value sampled at the tick wins.
- TRACK:
  - piston_q<target → compress=1. piston_q>target → expand=1.
  - step_en=tick while piston_q!=target.
  - piston_q==target → go to HOLD; compress/expand drop the same cycle.
  - The timeout counter increments on each tick. On reaching TIMEOUT_TICKS: fault=1, go to HOLD.
- HOLD:
  - No motion. settled=(piston_q==target).
  - Target change or piston_q!=target → go to TRACK and zero the timeout counter, unless fault=1, in which case stay in HOLD.
- Simultaneous events: mode change has priority over target change, settle and timeout.
- Latency:
  - Input change to updated target: 1 cycle.
  - Target to first step_en: at most STEP_DIV+1 cycles.
- Invariant: compress and expand are never both 1. step_en is never 1 without exactly one of them.

Decomposition:
- Shared package:
  - mode encodings MODE_MANUAL/TEMP/MOL.
  - state enum.
  - constants BORDER_MIN=1, BORDER_MAX=200, MOL_BASE=201, TEMP_BASE=161, STEP_PER_UNIT=40.
- One natural sub-module, step_tick_gen: a parameterised free-running divider with tick output. The FSM and target logic stay in the top.

Test Plan:
- Reset with mode_sel=00, then release → all outputs 0, mode_cur=00, target=1; compress_btn=1 gives step_en every 4 cycles with compress=1.
- Both buttons pressed in MANUAL → compress=expand=step_en=0 for 20 cycles.
- mode_sel=10, num_moles=3, piston_q=1 → SWITCH until tick, then TRACK with target=81 and compress=1. Model the counter stepping q; settled=1 at q=81 with step_en=0.
- In HOLD at 81, change num_moles to 1 → target=161, TRACK, compress toward 161. Change temp to 5 while in temp mode → target saturates to 1.
- Hold piston_q frozen at 10 with target 121 and TIMEOUT_TICKS=8 → fault=1 after 8 ticks, state HOLD, no further step_en. Switching mode to 00 clears fault.
- Pull clearn low mid-TRACK → outputs clear within the same cycle, asynchronously. Released with mode_sel=01, temp=2 → SWITCH then TRACK to target 81.
